ksa: RTL and testbench



---
 rtl/ksa.sv | 129 ++++++++++++
 tb/tb_ksa.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the shared 256x8 S memory in place with a
// 24-bit key, six cycles per index (read i, latch, read j, latch, write i, write j).
module ksa (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    typedef enum logic [2:0] {
        IDLE,
        READ_I,
        LATCH_I,
        READ_J,
        LATCH_J,
        WRITE_I,
        WRITE_J,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  i, j, si, sj;
    logic [23:0] k;
    logic [1:0]  kidx;
    logic [7:0]  keybyte;

    always_comb begin
        case (kidx)
            2'd0:    keybyte = k[23:16];
            2'd1:    keybyte = k[15:8];
            default: keybyte = k[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i    <= '0;
            j    <= '0;
            si   <= '0;
            sj   <= '0;
            k    <= '0;
            kidx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        k    <= key;
                        i    <= '0;
                        j    <= '0;
                        kidx <= '0;
                    end
                end
                LATCH_I: begin
                    si <= rddata;
                    j  <= j + rddata + keybyte;
                end
                LATCH_J: begin
                    sj <= rddata;
                end
                WRITE_J: begin
                    // i stops at 255 so a completed run never wraps the index
                    if (i != 8'hFF) begin
                        i    <= i + 8'd1;
                        kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        addr      = '0;
        wrdata    = '0;
        wren      = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_nxt = READ_I;
            end
            READ_I: begin
                addr      = i;
                state_nxt = LATCH_I;
            end
            LATCH_I: begin
                state_nxt = READ_J;
            end
            READ_J: begin
                addr      = j;
                state_nxt = LATCH_J;
            end
            LATCH_J: begin
                state_nxt = WRITE_I;
            end
            WRITE_I: begin
                addr      = i;
                wrdata    = sj;
                wren      = 1'b1;
                state_nxt = WRITE_J;
            end
            WRITE_J: begin
                addr      = j;
                wrdata    = si;
                wren      = 1'b1;
                state_nxt = (i == 8'hFF) ? DONE : READ_I;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: behavioural S memory, reference RC4 KSA model and a byte
// scoreboard compared against memory contents when each run completes.
module tb_ksa;

    typedef logic [7:0] sarr_t [256];

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    sarr_t       mem;
    sarr_t       init_img;
    logic        load;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          wr_cnt = 0;
    int          t0     = 0;
    int          wr0    = 0;
    logic [7:0]  exp_q [$];
    sarr_t       ident;

    ksa dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int a = 0; a < 256; a++) mem[a] <= init_img[a];
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

    always @(posedge clk) begin
        cyc++;
        if (wren) wr_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic sarr_t ksa_ref(input sarr_t s_in, input logic [23:0] kk, input int unsigned n);
        sarr_t      s;
        logic [7:0] jj;
        logic [7:0] t;
        logic [7:0] kb;
        s  = s_in;
        jj = 8'd0;
        for (int unsigned ii = 0; ii < n; ii++) begin
            case (ii % 3)
                0:       kb = kk[23:16];
                1:       kb = kk[15:8];
                default: kb = kk[7:0];
            endcase
            jj    = jj + s[ii] + kb;
            t     = s[ii];
            s[ii] = s[jj];
            s[jj] = t;
        end
        return s;
    endfunction

    task automatic push_exp(input sarr_t e);
        for (int a = 0; a < 256; a++) exp_q.push_back(e[a]);
    endtask

    task automatic load_s(input sarr_t s);
        init_img = s;
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Ends #1 after the accepting edge with en dropped.
    task automatic start_run(input logic [23:0] kk, input sarr_t pre, input bit track);
        if (track) push_exp(ksa_ref(pre, kk, 256));
        @(negedge clk);
        en  = 1'b1;
        key = kk;
        @(posedge clk);
        #1;
        t0  = cyc;
        wr0 = wr_cnt;
        en  = 1'b0;
        check("accept_busy", rdy, 1'b0);
    endtask

    task automatic wait_done(input string tag, input bit track);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, n < 3000, 1'b1);
        if (track) begin
            check({tag, "_latency"}, cyc - t0, 1537);
            check({tag, "_writes"}, wr_cnt - wr0, 512);
            if (exp_q.size() < 256) begin
                check({tag, "_sb_size"}, exp_q.size(), 256);
            end else begin
                for (int a = 0; a < 256; a++) begin
                    check($sformatf("%s_S[%0d]", tag, a), mem[a], exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        sarr_t       pre;
        sarr_t       mid;
        sarr_t       e1;
        logic [7:0]  t;
        logic [23:0] kk;
        int          r;
        int          w;
        int          n;

        for (int a = 0; a < 256; a++) ident[a] = 8'(a);
        rst  = 1'b1;
        en   = 1'b0;
        key  = '0;
        load = 1'b0;
        #1;
        check("rst_rdy", rdy, 1'b1);
        check("rst_wren", wren, 1'b0);
        check("rst_addr", addr, 8'd0);
        check("rst_wrdata", wrdata, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // all-zero key: early iterations visible mid-run, j wraps past 255 later
        load_s(ident);
        start_run(24'h000000, ident, 1'b1);
        repeat (18) @(posedge clk);
        #1;
        mid = ksa_ref(ident, 24'h000000, 3);
        for (int a = 0; a < 4; a++) check($sformatf("k0_it3_S[%0d]", a), mem[a], mid[a]);
        check("k0_S2_is_3", mem[2], 8'd3);
        check("k0_S3_is_2", mem[3], 8'd2);
        wait_done("k0", 1'b1);

        load_s(ident);
        start_run(24'h00033C, ident, 1'b1);
        wait_done("k033c", 1'b1);

        // en pulse and key change mid-run must not disturb the run
        load_s(ident);
        start_run(24'hA55A01, ident, 1'b1);
        repeat (600) @(posedge clk);
        @(negedge clk);
        en  = 1'b1;
        key = 24'hFFFFFF;
        @(posedge clk);
        #1;
        en  = 1'b0;
        key = 24'h123456;
        check("midrun_en_ignored", rdy, 1'b0);
        wait_done("hs", 1'b1);

        // random permutation with key byte 0 chosen so j == i at i = 0
        pre = ident;
        for (int a = 255; a > 0; a--) begin
            r      = $urandom_range(a, 0);
            t      = pre[a];
            pre[a] = pre[r];
            pre[r] = t;
        end
        kk        = 24'($urandom);
        kk[23:16] = 8'(0) - pre[0];
        load_s(pre);
        start_run(kk, pre, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("ieqj_S0_unchanged", mem[0], pre[0]);
        wait_done("rnd", 1'b1);

        // reset mid-run: outputs drop immediately, no further writes
        load_s(ident);
        start_run(24'h010203, ident, 1'b0);
        repeat (300) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_rdy", rdy, 1'b1);
        check("midrun_rst_wren", wren, 1'b0);
        check("midrun_rst_addr", addr, 8'd0);
        w = wr_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_writes", wr_cnt, w);
        check("post_rst_idle", rdy, 1'b1);

        // en held high: second run follows after a single idle cycle
        load_s(ident);
        kk = 24'h0BADF0;
        e1 = ksa_ref(ident, kk, 256);
        push_exp(ksa_ref(e1, kk, 256));
        @(negedge clk);
        en  = 1'b1;
        key = kk;
        @(posedge clk);
        #1;
        t0 = cyc;
        n  = 0;
        while (rdy !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_first_done", n < 3000, 1'b1);
        check("b2b_first_latency", cyc - t0, 1537);
        @(posedge clk);
        #1;
        check("b2b_rdy_one_cycle", rdy, 1'b0);
        t0  = cyc;
        wr0 = wr_cnt;
        en  = 1'b0;
        wait_done("b2b", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
